// File: rtl/ami_tx_serializer.sv
// Serializes a captured AMI result word into WORD_W beats, most-significant word
// first, with an optional trailing XOR checksum beat and a completed-frame counter.
module ami_tx_serializer #(
  parameter int DATA_W  = 256,
  parameter int WORD_W  = 32,
  parameter int CSUM_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ami_data_in,
  input  logic              ami_valid,
  output logic              ami_ack,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int BEATS = DATA_W / WORD_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] CSUM = 2'd2;

  logic [1:0]                   state_reg, state_next;
  logic [CNT_W-1:0]             beat_cnt_reg, beat_cnt_next;
  logic [WORD_W-1:0]            csum_reg, csum_next;
  logic [15:0]                  frame_cnt_reg, frame_cnt_next;
  logic                         ack_reg, ack_next;
  logic [BEATS-1:0][WORD_W-1:0] hold_reg;

  logic [WORD_W-1:0] beat_word;
  logic              last_beat;
  logic              capture;

  assign beat_word = hold_reg[LAST_CNT - beat_cnt_reg];
  assign last_beat = (beat_cnt_reg == LAST_CNT);
  assign capture   = (state_reg == IDLE) && ami_valid;

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    csum_next      = csum_reg;
    frame_cnt_next = frame_cnt_reg;
    ack_next       = capture;
    case (state_reg)
      IDLE: begin
        if (ami_valid) begin
          state_next    = SEND;
          beat_cnt_next = '0;
          csum_next     = '0;
        end
      end
      SEND: begin
        if (out_ready) begin
          csum_next = csum_reg ^ beat_word;
          if (last_beat) begin
            // Counter parks on the last index so it never exceeds BEATS-1.
            if (CSUM_EN != 0) begin
              state_next = CSUM;
            end else begin
              state_next     = IDLE;
              frame_cnt_next = frame_cnt_reg + 16'd1;
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
        end
      end
      CSUM: begin
        if (out_ready) begin
          state_next     = IDLE;
          frame_cnt_next = frame_cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      beat_cnt_reg  <= '0;
      csum_reg      <= '0;
      frame_cnt_reg <= '0;
      ack_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      csum_reg      <= csum_next;
      frame_cnt_reg <= frame_cnt_next;
      ack_reg       <= ack_next;
    end
  end

  // Payload storage carries no reset so it can map onto plain fabric registers.
  always_ff @(posedge clk) begin
    if (capture) begin
      hold_reg <= ami_data_in;
    end
  end

  always_comb begin
    out_data = '0;
    if (state_reg == SEND) begin
      out_data = beat_word;
    end else if (state_reg == CSUM) begin
      out_data = csum_reg;
    end
  end

  assign out_valid = (state_reg != IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_last  = (state_reg == CSUM) ||
                     ((state_reg == SEND) && (CSUM_EN == 0) && last_beat);
  assign ami_ack   = ack_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_ami_tx_serializer.sv
// Directed bench for ami_tx_serializer: default build with checksum plus a
// CSUM_EN=0 build, checking beat order, stalls, ack timing, reset and wrap.
module tb_ami_tx_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] ami_data_in;
  logic         ami_valid;
  logic         ami_ack;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic [15:0]  frame_cnt;

  logic         nc_valid;
  logic         nc_ack;
  logic [31:0]  nc_data;
  logic         nc_out_valid;
  logic         nc_ready;
  logic         nc_last;
  logic         nc_busy;
  logic [15:0]  nc_frame_cnt;

  int total = 0;
  int bad   = 0;

  logic [255:0] d1;
  logic [255:0] d2;

  always #5 clk = ~clk;

  ami_tx_serializer dut (
    .clk(clk), .rst(rst), .ami_data_in(ami_data_in), .ami_valid(ami_valid),
    .ami_ack(ami_ack), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
  );

  ami_tx_serializer #(.CSUM_EN(0)) dut_nc (
    .clk(clk), .rst(rst), .ami_data_in(ami_data_in), .ami_valid(nc_valid),
    .ami_ack(nc_ack), .out_data(nc_data), .out_valid(nc_out_valid),
    .out_ready(nc_ready), .out_last(nc_last), .busy(nc_busy), .frame_cnt(nc_frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in the capture cycle with out_ready=1, checks all 8 beats then the checksum beat.
  task automatic drain(input logic [255:0] d, input logic [31:0] cs);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("beat%0d", k), out_data, d[(7-k)*32 +: 32]);
      chk("beat_last", {31'd0, out_last}, 32'd0);
      if (k > 0) chk("beat_ack", {31'd0, ami_ack}, 32'd0);
      tick();
    end
    chk("csum", out_data, cs);
    chk("csum_last", {31'd0, out_last}, 32'd1);
    chk("csum_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic capture(input logic [255:0] d);
    ami_data_in = d;
    ami_valid   = 1'b1;
    tick();
    ami_valid   = 1'b0;
    chk("ack", {31'd0, ami_ack}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_beat;
    int e;

    d1 = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    d2 = {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404,
          32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808};
    rst = 1'b0; ami_valid = 1'b0; out_ready = 1'b0; nc_valid = 1'b0; nc_ready = 1'b0;
    ami_data_in = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {31'd0, ami_ack}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic frame, out_ready held high
    out_ready = 1'b1;
    capture(d1);
    chk("busy", {31'd0, busy}, 32'd1);
    drain(d1, 32'h00000008);
    chk("fcnt1", {16'd0, frame_cnt}, 32'd1);

    // out_ready toggling 1,0,1,0...: 9 transfers in 17 cycles
    capture(d1);
    e = 0;
    for (int i = 0; i < 17; i++) begin
      out_ready = (i % 2 == 0);
      exp_beat = (e < 8) ? d1[(7-e)*32 +: 32] : 32'h00000008;
      chk($sformatf("stall_c%0d", i), out_data, exp_beat);
      chk("stall_last", {31'd0, out_last}, {31'd0, e == 8});
      if (out_ready) e++;
      tick();
    end
    chk("stall_xfers", e, 32'd9);
    chk("stall_idle", {31'd0, out_valid}, 32'd0);
    chk("fcnt2", {16'd0, frame_cnt}, 32'd2);
    out_ready = 1'b1;

    // ami_valid held with a second word during SEND: ignored until IDLE
    ami_data_in = d1;
    ami_valid   = 1'b1;
    tick();
    chk("hold_ack", {31'd0, ami_ack}, 32'd1);
    ami_data_in = d2;
    for (int k = 0; k < 9; k++) begin
      exp_beat = (k < 8) ? d1[(7-k)*32 +: 32] : 32'h00000008;
      chk($sformatf("hold_beat%0d", k), out_data, exp_beat);
      if (k > 0) chk("hold_noack", {31'd0, ami_ack}, 32'd0);
      tick();
    end
    chk("hold_gap_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_gap_ack", {31'd0, ami_ack}, 32'd0);
    chk("fcnt3", {16'd0, frame_cnt}, 32'd3);
    tick();
    ami_valid = 1'b0;
    chk("second_ack", {31'd0, ami_ack}, 32'd1);
    drain(d2, 32'h08080808);
    chk("fcnt4", {16'd0, frame_cnt}, 32'd4);

    // Reset mid-frame after beat 3 transferred
    capture(d1);
    tick();
    tick();
    tick();
    chk("pre_rst_beat", out_data, 32'd4);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_last", {31'd0, out_last}, 32'd0);
    chk("arst_fcnt", {16'd0, frame_cnt}, 32'd0);
    tick();
    rst = 1'b1;
    capture(d1);
    drain(d1, 32'h00000008);
    chk("post_rst_fcnt", {16'd0, frame_cnt}, 32'd1);

    // frame_cnt wrap
    force dut.frame_cnt_reg = 16'hFFFF;
    #1;
    release dut.frame_cnt_reg;
    chk("preload_fcnt", {16'd0, frame_cnt}, 32'h0000FFFF);
    tick();
    capture(d2);
    drain(d2, 32'h08080808);
    chk("wrap_fcnt", {16'd0, frame_cnt}, 32'd0);

    // CSUM_EN=0 build: 8 beats, out_last on the 8th, no checksum beat
    ami_data_in = d1;
    nc_valid = 1'b1;
    nc_ready = 1'b1;
    tick();
    nc_valid = 1'b0;
    chk("nc_ack", {31'd0, nc_ack}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("nc_beat%0d", k), nc_data, d1[(7-k)*32 +: 32]);
      chk("nc_last", {31'd0, nc_last}, {31'd0, k == 7});
      tick();
    end
    chk("nc_idle", {31'd0, nc_out_valid}, 32'd0);
    chk("nc_fcnt", {16'd0, nc_frame_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ami_tx_serializer.md
AMI_TX_SERIALIZER -- requirements
Module: ami_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 256, meaning the width of the captured AMI result word.
REQ-002 SHALL have parameter WORD_W, default 32, meaning the output beat width; DATA_W/WORD_W SHALL be an integer (8 at defaults).
REQ-003 SHALL have parameter CSUM_EN, default 1, meaning a trailing XOR checksum beat is appended when 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port ami_data_in, input, DATA_W bits: the 256-bit result driven by the MCSE top on mcse_ami_out.
REQ-007 SHALL have port ami_valid, input, 1 bit: ami_data_in holds a new result.
REQ-008 SHALL have port ami_ack, output, 1 bit: one-cycle pulse confirming capture, returned to the MCSE top.
REQ-009 SHALL have port out_data, output, WORD_W bits: the current beat.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream sink accepts the beat.
REQ-012 SHALL have port out_last, output, 1 bit: the final beat of the frame.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port frame_cnt, output, 16 bits: count of frames fully sent.

Function
REQ-015 SHALL implement states IDLE, SEND and CSUM; CSUM is unreachable when CSUM_EN=0.
REQ-016 IDLE with ami_valid=1 at a clock edge SHALL capture ami_data_in into a holding register, clear beat_cnt, pulse ami_ack high for exactly the next cycle and enter SEND.
REQ-017 ami_valid SHALL be ignored outside IDLE, with no capture and no ack; the upstream source holds ami_valid until it sees ami_ack.
REQ-018 In SEND, out_valid SHALL be 1 and out_data SHALL be the holding-register slice at index (DATA_W/WORD_W-1-beat_cnt), i.e. most-significant word first.
REQ-019 A beat SHALL transfer only on a cycle where out_valid=1 and out_ready=1; otherwise out_data, out_last and beat_cnt SHALL hold.
REQ-020 Each transfer in SEND SHALL XOR the beat into a WORD_W checksum register; that register SHALL be cleared at capture.
REQ-021 On transfer of beat DATA_W/WORD_W-1, SEND SHALL go to CSUM if CSUM_EN=1, otherwise to IDLE.
REQ-022 In CSUM, out_data SHALL equal the accumulated XOR of all beats and out_last SHALL be 1; on transfer the block SHALL return to IDLE.
REQ-023 When CSUM_EN=0, out_last SHALL be 1 during beat DATA_W/WORD_W-1 of SEND.
REQ-024 On the transfer of the final beat, frame_cnt SHALL increment by 1 and wrap from 0xFFFF to 0x0000.
REQ-025 After a frame ends, the block SHALL sit in IDLE for at least one cycle before the next capture, so the minimum frame period is beats+1 cycles.
REQ-026 out_ready=1 outside SEND and CSUM SHALL have no effect.
REQ-027 The beat counter SHALL be 3 bits at defaults (clog2 of the beat count in general) and SHALL never exceed DATA_W/WORD_W-1.

Reset
REQ-028 With rst=0, the block SHALL immediately force state to IDLE and ami_ack, out_valid, out_last, busy, beat_cnt, the checksum, out_data and frame_cnt to 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without counting it; after release the block SHALL accept a new capture on the first edge with ami_valid=1.
REQ-030 The holding register need not be reset.

Verification
REQ-031 Data word 0x00000001_00000002_..._00000008 with ami_valid for one edge and out_ready held 1 -> ami_ack for one cycle; beats 0x1 to 0x8 on consecutive cycles; checksum beat 0x00000008 with out_last=1; frame_cnt=1.
REQ-032 Same frame with out_ready toggling 1,0,1,0,... -> identical beat sequence with data stable while stalled; 9 transfers in 17 cycles.
REQ-033 ami_valid held high during SEND with a second word -> no ack and no capture until IDLE; second frame starts the cycle after the first frame's last beat plus one IDLE cycle.
REQ-034 rst pulsed low after beat 3 -> all outputs 0 asynchronously, frame_cnt unchanged (0); the next frame starts fresh from beat 0x1.
REQ-035 frame_cnt preloaded via 65535 frames (or forced), then one more frame -> frame_cnt reads 0x0000.
REQ-036 CSUM_EN=0 build -> 8 beats, out_last on the 8th beat, no checksum beat.
